// File: rtl/vending_pkg.sv
// Shared types for the multi-item vending controller: FSM states, coin codes and coin values.
package vending_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StVend,
    StChange
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  // Face value in rupees of a coin-acceptor code.
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    logic [4:0] value;
    case (code)
      COIN_5:  value = 5'd5;
      COIN_10: value = 5'd10;
      COIN_20: value = 5'd20;
      default: value = 5'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with registered sold-out flags and an availability lookup for the
// currently selected item.
module vend_stock_bank #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         dec_i,
  input  logic [$clog2(NUM_ITEMS)-1:0] dec_idx_i,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_i,
  output logic                         avail_o,
  output logic [NUM_ITEMS-1:0]         sold_out_o
);

  localparam int unsigned SelW = $clog2(NUM_ITEMS);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] sold_out_q;

  // Empty counters hold at zero rather than wrapping.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (dec_i && (dec_idx_i == SelW'(i)) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
  end

  // Out-of-range selects match no channel and read as unavailable.
  always_comb begin
    avail_o = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_i == SelW'(i)) avail_o = (stock_q[i] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
      sold_out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i]    <= stock_d[i];
        sold_out_q[i] <= (stock_q[i] == '0);
      end
    end
  end

  assign sold_out_o = sold_out_q;

endmodule

// File: rtl/vending_controller_multi.sv
// Multi-item coin vending controller with cancel/refund and serial change return.
// Optional inactivity refund is built only when VEND_TIMEOUT_EN is defined.
module vending_controller_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS      = 4,
  parameter int unsigned CREDIT_W       = 8,
  parameter int unsigned PRICE          = 15,
  parameter int unsigned UNIT           = 5,
  parameter int unsigned MAX_CREDIT     = 50,
  parameter int unsigned STOCK_W        = 4,
  parameter int unsigned INIT_STOCK     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   coin_i,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_i,
  input  logic                         buy_i,
  input  logic                         cancel_i,
  output logic                         dispense_o,
  output logic [$clog2(NUM_ITEMS)-1:0] dispense_item_o,
  output logic                         change_pulse_o,
  output logic                         coin_reject_o,
  output logic                         buy_err_o,
  output logic [CREDIT_W-1:0]          credit_o,
  output logic                         busy_o,
  output logic [NUM_ITEMS-1:0]         sold_out_o
);

  localparam int unsigned SelW = $clog2(NUM_ITEMS);
  localparam int unsigned SumW = CREDIT_W + 1;

  if (NUM_ITEMS < 2 || (PRICE % UNIT) != 0 || (MAX_CREDIT % UNIT) != 0 ||
      MAX_CREDIT >= (2 ** CREDIT_W) || MAX_CREDIT < PRICE || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("vending_controller_multi: inconsistent parameters");
  end

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic [SelW-1:0]     item_q, item_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                buy_err_q, buy_err_d;

  logic            avail;
  logic            active, coin_nz, cancel_acc, buy_acc, coin_acc, timeout;
  logic [SumW-1:0] coin_sum;

  vend_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_W   (STOCK_W),
    .INIT_STOCK(INIT_STOCK)
  ) u_stock (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .dec_i     (buy_acc),
    .dec_idx_i (sel_i),
    .sel_i     (sel_i),
    .avail_o   (avail),
    .sold_out_o(sold_out_o)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] idle_cnt_q, idle_cnt_d;
  logic           quiet;

  assign quiet      = (state_q == StCollect) && (coin_i == COIN_NONE) && !buy_i && !cancel_i;
  assign timeout    = quiet && (idle_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
  assign idle_cnt_d = (quiet && !timeout) ? idle_cnt_q + ToW'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_cnt_q <= '0;
    else         idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Event arbitration in IDLE/COLLECT: cancel > buy > coin; a refused buy does not block a coin.
  always_comb begin
    active     = (state_q == StIdle) || (state_q == StCollect);
    coin_nz    = (coin_i != COIN_NONE);
    coin_sum   = SumW'(credit_q) + SumW'(coin_value(coin_i));
    cancel_acc = cancel_i && (state_q == StCollect);
    buy_acc    = active && buy_i && !cancel_acc && (credit_q >= CREDIT_W'(PRICE)) && avail;
    coin_acc   = active && coin_nz && !cancel_acc && !buy_acc && (coin_sum <= SumW'(MAX_CREDIT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      item_q     <= '0;
      change_q   <= 1'b0;
      reject_q   <= 1'b0;
      buy_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      item_q     <= item_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
      buy_err_q  <= buy_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    unique case (state_q)
      StIdle, StCollect: begin
        if (cancel_acc || timeout) begin
          state_d = StChange;
        end else if (buy_acc) begin
          state_d  = StVend;
          credit_d = credit_q - CREDIT_W'(PRICE);
        end else if (coin_acc) begin
          state_d  = StCollect;
          credit_d = coin_sum[CREDIT_W-1:0];
        end
      end
      StVend: state_d = (credit_q != '0) ? StChange : StIdle;
      StChange: begin
        if (credit_q != '0) credit_d = credit_q - CREDIT_W'(UNIT);
        if (credit_q <= CREDIT_W'(UNIT)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dispense_d = buy_acc;
    item_d     = buy_acc ? sel_i : '0;
    change_d   = (state_q == StChange) && (credit_q != '0);
    reject_d   = coin_nz && !coin_acc;
    buy_err_d  = buy_i && !buy_acc;
  end

  assign dispense_o      = dispense_q;
  assign dispense_item_o = item_q;
  assign change_pulse_o  = change_q;
  assign coin_reject_o   = reject_q;
  assign buy_err_o       = buy_err_q;
  assign credit_o        = credit_q;
  assign busy_o          = (state_q == StVend) || (state_q == StChange);

endmodule

// File: doc/vending_controller_multi.md
Name: vending_controller_multi

Overview:
- Parametrised successor to the single-product coin vending FSM.
- Serves NUM_ITEMS products at a common PRICE, with per-item stock counters and a saturating credit accumulator.
- Adds coin rejection, cancel/refund, and serial change return in UNIT-valued pulses.
- Sits between the coin-acceptor decoder and the dispenser/change-hopper drivers.

Parameters:
- NUM_ITEMS, 4: number of product channels. Must be >= 2.
- CREDIT_W, 8: width of the credit accumulator.
- PRICE, 15: item price in rupees. Must be a multiple of UNIT.
- UNIT, 5: value of one change coin. Coin values 5, 10 and 20 must be multiples of UNIT.
- MAX_CREDIT, 50: credit ceiling. Must be a multiple of UNIT, less than 2**CREDIT_W, and >= PRICE.
- STOCK_W, 4: width of each stock counter.
- INIT_STOCK, 3: stock loaded into every channel at reset.
- TIMEOUT_CYCLES, 1000: inactivity limit. Used only with VEND_TIMEOUT_EN.

Ports:
- clk, in, 1: the single clock. All logic is on its rising edge.
- reset, in, 1: asynchronous, active-low reset. Asserts immediately; deassertion is synchronised externally.
- coin, in, 2: 00 = none, 01 = 5, 10 = 10, 11 = 20. Sampled every cycle.
- sel, in, $clog2(NUM_ITEMS): item select. Sampled together with buy.
- buy, in, 1: purchase request. Single-cycle level.
- cancel, in, 1: refund request.
- dispense, out, 1: one-cycle vend pulse.
- dispense_item, out, $clog2(NUM_ITEMS): item being vended. Valid while dispense=1.
- change_pulse, out, 1: each high cycle returns one UNIT coin.
- coin_reject, out, 1: one-cycle pulse; the coin sampled in the previous cycle was returned, not credited.
- buy_err, out, 1: one-cycle pulse; the buy was refused.
- credit, out, CREDIT_W: current credit.
- busy, out, 1: high in VEND and CHANGE.
- sold_out, out, NUM_ITEMS: bit i is high when stock[i]==0.

Behaviour:
- Reset values: state=IDLE, credit=0, every stock counter=INIT_STOCK. All pulse outputs, busy and dispense_item are 0; sold_out=0.
- All outputs are registered, so every response appears the cycle after the triggering input.
- States:
  - IDLE: credit==0.
  - COLLECT: credit>0.
  - VEND: exactly 1 cycle.
  - CHANGE: returns coins until credit is 0.
- Event priority in IDLE/COLLECT, one event accepted per cycle: cancel > buy > coin.
  - A nonzero coin arriving in the same cycle as an accepted cancel or buy pulses coin_reject.
- Coin accept:
  - If credit+value <= MAX_CREDIT, credit += value and IDLE moves to COLLECT.
  - Otherwise pulse coin_reject and leave credit unchanged.
- Buy is accepted when credit >= PRICE, stock[sel] > 0 and sel < NUM_ITEMS. On acceptance:
  - Go to VEND; in that cycle dispense=1 and dispense_item=sel.
  - Decrement stock[sel] and set credit -= PRICE.
  - Next state is CHANGE if credit > 0, else IDLE.
- Any other buy pulses buy_err. Credit and state are unchanged.
- Buy in IDLE always pulses buy_err.
- Cancel in COLLECT goes to CHANGE. Cancel in IDLE is ignored.
- CHANGE:
  - Each cycle: change_pulse=1 and credit -= UNIT.
  - When credit reaches 0, go to IDLE.
  - The N-th pulse appears N cycles after entering CHANGE.
- In VEND and CHANGE:
  - Every nonzero coin pulses coin_reject.
  - buy pulses buy_err.
  - cancel is ignored.
- Stock never decrements below 0; the counter does not wrap.
- sold_out updates in the cycle after the stock decrement.
- Reset asserted mid-operation (any state) aborts immediately to reset values. Pending change is lost; this is logged as a service event, not an RTL concern.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - An inactivity counter counts cycles in COLLECT with no coin, buy or cancel.
  - When it reaches TIMEOUT_CYCLES, the block enters CHANGE and refunds all credit, exactly as cancel does.
  - The counter clears on any input event or state exit.
- Undefined: no counter is built, and COLLECT holds indefinitely.

Decomposition:
- Shared package vending_pkg holds:
  - the state enum (IDLE, COLLECT, VEND, CHANGE);
  - coin codes COIN_NONE, COIN_5, COIN_10, COIN_20;
  - a coin_value function mapping code to rupees.
- Sub-module vend_stock_bank holds the NUM_ITEMS stock counters.
  - Inputs: decrement strobe and index.
  - Outputs: the sold_out vector and an "available" lookup for sel.

Test Plan (defaults):
- Coin 10, coin 10, buy sel=2 → dispense=1 with dispense_item=2; credit 20→5; one change_pulse; stock[2] 3→2; IDLE.
- Coin 5, then cancel → exactly 1 change_pulse; credit 5→0; IDLE; no dispense.
- Three buys of item 0, each funded with 15 → sold_out[0]=1. A fourth buy with credit 20 → buy_err; credit stays 20.
- Coins 20, 20, 10 (credit 50), then coin 5 → coin_reject; credit stays 50. Cancel → 10 change_pulses.
- Credit 10, same-cycle coin=10 and buy → buy_err; coin credited, credit 20. Next buy → dispense, one change_pulse.
- Credit 50, cancel, reset low after 3 change_pulses → all outputs 0 asynchronously; stock=INIT_STOCK. With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=8: credit 5, idle for 8 cycles → 1 change_pulse.
